fifo_rd_stream: RTL and testbench

Read-side consumer for the team's dual-clock FIFO. It sits in the read clock domain, drains the FIFO's read port (`rdata`/`rempty`/`rinc`) into a 2-entry registered buffer, and presents the data as a valid/ready stream. The stream is framed into fixed-length bursts with a `m_last` marker. It decouples downstream backpressure from the FIFO pop timing while sustaining one word per cycle.

---
 rtl/fifo_rd_stream_pkg.sv | 18 +
 rtl/rd_skid_buf.sv | 73 +++++++
 rtl/fifo_rd_stream.sv | 85 ++++++++
 tb/tb_fifo_rd_stream.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream consumer.
package fifo_rd_stream_pkg;

    // Occupancy of the 2-entry head/tail buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    localparam int unsigned WORD_CNT_W = 32;

    // Beat counter width: at least one bit even for single-beat bursts
    function automatic int unsigned beat_cnt_w(input int unsigned burst);
        return (burst <= 32'd1) ? 32'd1 : 32'(unsigned'($clog2(burst)));
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry head/tail buffer with its occupancy FSM; head is the stream word.
module rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DSIZE = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             accept_i,
    input  logic [DSIZE-1:0] wdata_i,
    output logic [DSIZE-1:0] head_o,
    output occ_state_e       state_o
);

    occ_state_e       state_q, state_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;

    // State and storage registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Occupancy transitions; a push is never offered while full
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push_i) begin
                        head_d  = wdata_i;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push_i && accept_i) begin
                        head_d = wdata_i;
                    end else if (push_i) begin
                        tail_d  = wdata_i;
                        state_d = OCC_TWO;
                    end else if (accept_i) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (accept_i) begin
                        head_d  = tail_q;
                        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    assign head_o  = head_q;
    assign state_o = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the dual-clock FIFO read port into a valid/ready stream framed
// into BURST-beat bursts. Optional accepted-beat counter: FIFO_RD_WORDCNT_EN.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned BURST = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             flush,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
`ifdef FIFO_RD_WORDCNT_EN
    ,
    output logic [WORD_CNT_W-1:0] word_cnt
`endif
);

    localparam int unsigned   BW       = beat_cnt_w(BURST);
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST - 1);

    occ_state_e    state;
    logic          accept;
    logic [BW-1:0] beat_q, beat_d;

    // Pop only from registered occupancy so the FIFO never sees m_ready
    assign rinc    = !rempty && (state != OCC_TWO) && !flush && !rrst;
    assign m_valid = (state != OCC_EMPTY);
    assign accept  = m_valid && m_ready && !flush;
    assign m_last  = m_valid && (beat_q == BEAT_MAX);

    rd_skid_buf #(
        .DSIZE (DSIZE)
    ) u_buf (
        .clk_i    (rclk),
        .rst_i    (rrst),
        .flush_i  (flush),
        .push_i   (rinc),
        .accept_i (accept),
        .wdata_i  (rdata),
        .head_o   (m_data),
        .state_o  (state)
    );

    // Burst position register
    always_ff @(posedge rclk) begin
        if (rrst) beat_q <= '0;
        else      beat_q <= beat_d;
    end

    // Burst position advances per accepted beat, cleared by flush
    always_comb begin
        beat_d = beat_q;
        if (flush) begin
            beat_d = '0;
        end else if (accept) begin
            beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + BW'(1);
        end
    end

`ifdef FIFO_RD_WORDCNT_EN
    logic [WORD_CNT_W-1:0] wcnt_q, wcnt_d;

    // Accepted-beat counter register; survives flush
    always_ff @(posedge rclk) begin
        if (rrst) wcnt_q <= '0;
        else      wcnt_q <= wcnt_d;
    end

    // Count every accepted beat, wrapping naturally
    always_comb begin
        wcnt_d = wcnt_q;
        if (accept) wcnt_d = wcnt_q + WORD_CNT_W'(1);
    end

    assign word_cnt = wcnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized and directed bench for fifo_rd_stream against a queue-based model.
module tb_fifo_rd_stream;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned BURST = 4;

    logic             rclk = 1'b0;
    logic             rrst = 1'b1;
    logic [DSIZE-1:0] rdata = '0;
    logic             rempty = 1'b1;
    logic             rinc;
    logic             flush = 1'b0;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             m_last;
`ifdef FIFO_RD_WORDCNT_EN
    logic [31:0]      word_cnt;
`endif

    fifo_rd_stream #(
        .DSIZE (DSIZE),
        .BURST (BURST)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rdata    (rdata),
        .rempty   (rempty),
        .rinc     (rinc),
        .flush    (flush),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last)
`ifdef FIFO_RD_WORDCNT_EN
        ,
        .word_cnt (word_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;

    // Words still inside the FIFO, popped whenever the DUT asserts rinc
    logic [DSIZE-1:0] fifo_q[$];
    // Reference: words held by the consumer, in delivery order
    logic [DSIZE-1:0] buf_q[$];
    logic [DSIZE-1:0] head_val = '0;
    int unsigned      beat = 0;
    logic [31:0]      wc = '0;
    int unsigned      rinc_seen = 0;
    logic [DSIZE-1:0] next_word = 8'h11;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_words(input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            fifo_q.push_back(next_word);
            next_word = next_word + 8'd1;
        end
    endtask

    // One read-clock cycle: drive, check against the model, advance both
    task automatic cycle(input bit rst, input bit fl, input bit rdy, input bit chk);
        bit exp_valid, exp_last, exp_rinc, acc, obs_rinc;
        logic [DSIZE-1:0] head_word;
        @(negedge rclk);
        rrst    = rst;
        flush   = fl;
        m_ready = rdy;
        rempty  = (fifo_q.size() == 0);
        rdata   = rempty ? DSIZE'($urandom) : fifo_q[0];
        head_word = rdata;
        #1;
        exp_valid = (buf_q.size() != 0);
        exp_last  = exp_valid && (beat == BURST - 1);
        exp_rinc  = !rempty && (buf_q.size() < 2) && !fl && !rst;
        if (chk) begin
            check("rinc",    32'(rinc),    32'(exp_rinc));
            check("m_valid", 32'(m_valid), 32'(exp_valid));
            check("m_last",  32'(m_last),  32'(exp_last));
            check("m_data",  32'(m_data),  32'(head_val));
`ifdef FIFO_RD_WORDCNT_EN
            check("word_cnt", word_cnt, wc);
`endif
        end
        obs_rinc = rinc;
        if (obs_rinc) rinc_seen++;
        if (rst) begin
            buf_q.delete();
            head_val = '0;
            beat = 0;
            wc = '0;
        end else if (fl) begin
            buf_q.delete();
            beat = 0;
        end else begin
            acc = exp_valid && rdy;
            if (acc) begin
                void'(buf_q.pop_front());
                beat = (beat + 1) % BURST;
                wc = wc + 32'd1;
            end
            if (exp_rinc) buf_q.push_back(head_word);
            if (buf_q.size() != 0) head_val = buf_q[0];
        end
        @(posedge rclk);
        if (obs_rinc && fifo_q.size() != 0) void'(fifo_q.pop_front());
        cyc++;
    endtask

    initial begin
        // Reset with a non-empty FIFO: no pops while held
        push_words(8);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        // Streaming 0x11..0x18 with ready held high
        for (int i = 0; i < 11; i++) cycle(0, 0, 1, 1);

        // Backpressure: exactly two pops with five words queued
        push_words(5);
        rinc_seen = 0;
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
        check("bp_pops", 32'(rinc_seen), 32'd2);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 1);

        // Ready toggling over a continuous stream
        push_words(12);
        for (int i = 0; i < 18; i++) cycle(0, 0, (i % 3) != 1, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1);

        // Flush with a full buffer mid-burst, then a fresh burst
        push_words(10);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 1, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1);

        // Beat count across a flush, then reset clears it
        cycle(1, 0, 0, 1);
        push_words(13);
        for (int i = 0; i < 11; i++) cycle(0, 0, 1, 1);
        cycle(0, 1, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) push_words($urandom_range(1, 3));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) != 0, 1);
        end
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
